buffer_wr_arbiter: RTL and testbench

BUFFER_WR_ARBITER -- requirements
Module: buffer_wr_arbiter

---
 rtl/buffer_wr_arbiter_pkg.sv | 21 ++
 rtl/buffer_wr_arbiter_if.sv | 42 ++++
 rtl/buffer_wr_arbiter_rr.sv | 29 ++
 rtl/buffer_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_buffer_wr_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/buffer_wr_arbiter_pkg.sv
// Shared types and default sizes for the two-requester packet-buffer write arbiter.
// Contents: FSM state enum, default DATA_W/DEPTH/TIMEOUT, one-hot grant helper.
package buffer_arb_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned DEPTH_DEF   = 64;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        COMMIT = 2'd2,
        ABORT  = 2'd3
    } state_t;

    // Requester index to one-hot grant vector.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/buffer_wr_arbiter_if.sv
// Bus bundle between the two write requesters, the arbiter and the packet buffer.
// slave  : arbiter view (requests/writes/buf_full in; grant and buffer controls out).
// master : environment view (the mirror image).
interface buffer_wr_arbiter_if
    import buffer_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [1:0]        req;
    logic [1:0]        wr_en;
    logic [ADDR_W-1:0] wr_addr0;
    logic [ADDR_W-1:0] wr_addr1;
    logic [DATA_W-1:0] wr_data0;
    logic [DATA_W-1:0] wr_data1;
    logic [1:0]        last;
    logic [1:0]        grant;
    logic              buf_full;
    logic              buf_next;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              buf_commit;
    logic              buf_abort;
    logic [ADDR_W:0]   pkt_len;
    logic              overflow;

    modport slave (
        input  req, wr_en, wr_addr0, wr_addr1, wr_data0, wr_data1, last, buf_full,
        output grant, buf_next, buf_we, buf_addr, buf_data, buf_commit, buf_abort,
               pkt_len, overflow
    );

    modport master (
        output req, wr_en, wr_addr0, wr_addr1, wr_data0, wr_data1, last, buf_full,
        input  grant, buf_next, buf_we, buf_addr, buf_data, buf_commit, buf_abort,
               pkt_len, overflow
    );

endinterface

// File: rtl/buffer_wr_arbiter_rr.sv
// 2-way round-robin pointer and winner select.
// Ports: clock, reset (sync, active-low), req (requests), upd (release pulse),
//        done_idx (requester being released), win_c (combinational winner index).
module buffer_arb_rr
    import buffer_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       done_idx,
    output logic       win_c
);

    logic pref_q;

    // Preferred requester for a tie; the one just released loses the next tie.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pref_q <= 1'b0;
        end else if (upd) begin
            pref_q <= ~done_idx;
        end
    end

    // Tie goes to the preferred side, otherwise the only requester wins.
    assign win_c = (req == 2'b11) ? pref_q : req[1];

endmodule

// File: rtl/buffer_wr_arbiter.sv
// Arbitrates two requesters for the write side of a packet buffer: opens a slot,
// forwards the owner's words, then commits (on last) or aborts (owner drops req).
// Ports: clock, reset (sync, active-low), bus (buffer_wr_arbiter_if.slave).
// Build option: BUFFER_ARB_TIMEOUT_EN adds an idle-grant timer that aborts after
// TIMEOUT cycles without a forwarded write.
module buffer_wr_arbiter
    import buffer_arb_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clock,
    input  logic               reset,
    buffer_wr_arbiter_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PLEN_W = ADDR_W + 1;

    state_t            state_q, state_d;
    logic              owner_q;
    logic [1:0]        grant_q;
    logic [PLEN_W-1:0] pkt_len_q;
    logic              overflow_q;

    logic              win_c;
    logic              upd_c;
    logic              buf_next_c;
    logic              start_c;
    logic              wr_hit_c;
    logic              room_c;
    logic              fwd_c;
    logic              close_c;
    logic              tmo_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] data_c;

    buffer_arb_rr u_rr (
        .clock    (clock),
        .reset    (reset),
        .req      (bus.req),
        .upd      (upd_c),
        .done_idx (owner_q),
        .win_c    (win_c)
    );

    // Owner write qualification; writes past DEPTH are dropped but still seen for last.
    assign start_c  = (state_q == IDLE) && !bus.buf_full && (|bus.req);
    assign wr_hit_c = (state_q == GRANT) && bus.wr_en[owner_q];
    assign room_c   = (pkt_len_q != PLEN_W'(DEPTH));
    assign fwd_c    = wr_hit_c && room_c;
    assign close_c  = wr_hit_c && bus.last[owner_q];
    assign addr_c   = owner_q ? bus.wr_addr1 : bus.wr_addr0;
    assign data_c   = owner_q ? bus.wr_data1 : bus.wr_data0;

    // Next-state and pulse decode.
    always_comb begin
        state_d    = state_q;
        buf_next_c = 1'b0;
        upd_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_c) begin
                    state_d    = GRANT;
                    buf_next_c = 1'b1;
                end
            end
            GRANT: begin
                if (close_c) begin
                    state_d = COMMIT;
                end else if (!bus.req[owner_q] || tmo_c) begin
                    state_d = ABORT;
                end
            end
            COMMIT, ABORT: begin
                state_d = IDLE;
                upd_c   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, ownership, packet length and sticky overflow.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            grant_q    <= 2'b00;
            pkt_len_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (buf_next_c) begin
                owner_q   <= win_c;
                grant_q   <= onehot2(win_c);
                pkt_len_q <= '0;
            end else begin
                if (state_d != GRANT) begin
                    grant_q <= 2'b00;
                end
                if (fwd_c) begin
                    pkt_len_q <= pkt_len_q + PLEN_W'(1);
                end
            end
            if (wr_hit_c && !room_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef BUFFER_ARB_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] tmr_q;

    // Idle-grant timer: restarts on slot open and on every forwarded word.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tmr_q <= '0;
        end else if (buf_next_c || fwd_c) begin
            tmr_q <= '0;
        end else if ((state_q == GRANT) && !tmo_c) begin
            tmr_q <= tmr_q + TMR_W'(1);
        end
    end

    assign tmo_c = (state_q == GRANT) && (tmr_q == TMR_W'(TIMEOUT));
`else
    // TIMEOUT only matters when the idle timer is built in.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign tmo_c          = 1'b0;
`endif

    assign bus.grant      = grant_q;
    assign bus.buf_next   = buf_next_c;
    assign bus.buf_we     = fwd_c;
    assign bus.buf_addr   = addr_c;
    assign bus.buf_data   = data_c;
    assign bus.buf_commit = (state_q == COMMIT);
    assign bus.buf_abort  = (state_q == ABORT);
    assign bus.pkt_len    = pkt_len_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_buffer_wr_arbiter.sv
// Scoreboard bench for buffer_wr_arbiter: stimulus pushes expected buffer events,
// a negedge monitor pops and compares each event the DUT emits.
module tb_buffer_wr_arbiter;

    localparam int unsigned DW  = 8;
    localparam int unsigned DP  = 64;
    localparam int unsigned TMO = 16;
    localparam int EV_NEXT   = 1;
    localparam int EV_WE     = 2;
    localparam int EV_COMMIT = 3;
    localparam int EV_ABORT  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int n_next   = 0;
    int n_commit = 0;
    int n_abort  = 0;

    logic [31:0] sbq[$];

    buffer_wr_arbiter_if #(.DATA_W(DW), .DEPTH(DP)) bif ();

    buffer_wr_arbiter #(.DATA_W(DW), .DEPTH(DP), .TIMEOUT(TMO)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_ev(input int kind, input logic [1:0] g,
                                          input logic [5:0] a, input logic [7:0] d,
                                          input logic [6:0] len);
        return {5'd0, 4'(kind), g, a, d, len};
    endfunction

    function automatic logic [1:0] oh(input int who);
        return (who == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic see(input logic [31:0] act);
        logic [31:0] exp;
        chk_cnt++;
        if (sbq.size() == 0) begin
            $display("FAIL sb_unexpected: got event %08h want none", act);
        end else begin
            exp = sbq.pop_front();
            if (act === exp) pass_cnt++;
            else $display("FAIL sb_event: got %08h want %08h", act, exp);
        end
    endtask

    // Monitor: every buffer-side event is matched against the scoreboard.
    always @(negedge clk) begin
        if (bif.buf_next === 1'b1) begin
            n_next++;
            see(mk_ev(EV_NEXT, bif.grant, 6'd0, 8'd0, 7'd0));
        end
        if (bif.buf_we === 1'b1)
            see(mk_ev(EV_WE, bif.grant, bif.buf_addr, bif.buf_data, bif.pkt_len));
        if (bif.buf_commit === 1'b1) begin
            n_commit++;
            see(mk_ev(EV_COMMIT, bif.grant, 6'd0, 8'd0, bif.pkt_len));
        end
        if (bif.buf_abort === 1'b1) begin
            n_abort++;
            see(mk_ev(EV_ABORT, bif.grant, 6'd0, 8'd0, bif.pkt_len));
        end
    end

    // Owner writes n words (base+i at index i); the other requester strobes junk.
    task automatic write_words(input int who, input int n, input int base, input bit with_last);
        for (int i = 0; i < n; i++) begin
            bif.wr_en = 2'b11;
            bif.last  = (with_last && i == n - 1) ? oh(who) : 2'b00;
            if (who == 0) begin
                bif.wr_addr0 = 6'(i);  bif.wr_data0 = 8'(base + i);
                bif.wr_addr1 = 6'd63;  bif.wr_data1 = 8'hEE;
            end else begin
                bif.wr_addr1 = 6'(i);  bif.wr_data1 = 8'(base + i);
                bif.wr_addr0 = 6'd63;  bif.wr_data0 = 8'hEE;
            end
            if (i < int'(DP))
                sbq.push_back(mk_ev(EV_WE, oh(who), 6'(i), 8'(base + i), 7'(i)));
            cyc();
        end
        bif.wr_en = 2'b00;
        bif.last  = 2'b00;
    endtask

    // One full packet starting from IDLE with req already raised.
    task automatic pkt(input int who, input int n, input int base, input logic [1:0] req_after);
        sbq.push_back(mk_ev(EV_NEXT, 2'b00, 6'd0, 8'd0, 7'd0));
        cyc();
        chk($sformatf("grant_r%0d", who), 32'(bif.grant), 32'(oh(who)));
        write_words(who, n, base, 1'b1);
        sbq.push_back(mk_ev(EV_COMMIT, 2'b00, 6'd0, 8'd0, 7'((n > int'(DP)) ? int'(DP) : n)));
        bif.req = req_after;
        cyc();
    endtask

    initial begin
        int base_cnt;
        bif.req = 2'b00;  bif.wr_en = 2'b00;  bif.last = 2'b00;  bif.buf_full = 1'b0;
        bif.wr_addr0 = '0; bif.wr_addr1 = '0; bif.wr_data0 = '0; bif.wr_data1 = '0;

        // Reset state
        cyc(); cyc();
        chk("rst_grant", 32'(bif.grant), 0);
        chk("rst_len", 32'(bif.pkt_len), 0);
        chk("rst_ovf", 32'(bif.overflow), 0);
        chk("rst_pulses", 32'({bif.buf_next, bif.buf_we, bif.buf_commit, bif.buf_abort}), 0);
        rst_n = 1'b1;
        cyc();

        // Single requester, 8 words 100..107; a stray last without wr_en first
        bif.req = 2'b01;
        sbq.push_back(mk_ev(EV_NEXT, 2'b00, 6'd0, 8'd0, 7'd0));
        cyc();
        chk("s1_grant", 32'(bif.grant), 32'h1);
        bif.last = 2'b01;
        cyc();
        bif.last = 2'b00;
        write_words(0, 8, 100, 1'b1);
        sbq.push_back(mk_ev(EV_COMMIT, 2'b00, 6'd0, 8'd0, 7'd8));
        bif.req = 2'b00;
        cyc();
        chk("s1_len", 32'(bif.pkt_len), 8);
        chk("s1_ovf", 32'(bif.overflow), 0);
        chk("s1_commits", 32'(n_commit), 1);

        // Reset mid-packet: no abort/commit pulse, slot state cleared
        bif.req = 2'b01;
        sbq.push_back(mk_ev(EV_NEXT, 2'b00, 6'd0, 8'd0, 7'd0));
        cyc();
        write_words(0, 2, 30, 1'b0);
        rst_n   = 1'b0;
        bif.req = 2'b00;
        cyc(); cyc();
        chk("rstmid_grant", 32'(bif.grant), 0);
        chk("rstmid_len", 32'(bif.pkt_len), 0);
        chk("rstmid_pulses", 32'(n_abort + n_commit), 1);
        rst_n = 1'b1;
        cyc();

        // Both requesting from reset: 0, then 1 (req0 still high), then 0 again
        bif.req = 2'b11;
        pkt(0, 3, 20, 2'b11);
        pkt(1, 2, 40, 2'b11);
        pkt(0, 1, 60, 2'b00);

        // buf_full holds off the slot open for 10 cycles
        bif.buf_full = 1'b1;
        bif.req      = 2'b10;
        base_cnt     = n_next;
        repeat (10) cyc();
        chk("full_no_next", 32'(n_next), 32'(base_cnt));
        chk("full_no_grant", 32'(bif.grant), 0);
        bif.buf_full = 1'b0;
        sbq.push_back(mk_ev(EV_NEXT, 2'b00, 6'd0, 8'd0, 7'd0));
        cyc();
        chk("full_grant", 32'(bif.grant), 32'h2);

        // Owner 1 writes 4 words then drops req -> abort
        base_cnt = n_commit;
        write_words(1, 4, 70, 1'b0);
        bif.req = 2'b00;
        cyc();
        sbq.push_back(mk_ev(EV_ABORT, 2'b00, 6'd0, 8'd0, 7'd4));
        cyc();
        chk("abort_grant", 32'(bif.grant), 0);
        chk("abort_no_commit", 32'(n_commit), 32'(base_cnt));

        // DEPTH+2 writes: DEPTH forwarded, overflow set, commit on last
        bif.req = 2'b01;
        pkt(0, int'(DP) + 2, 0, 2'b00);
        chk("ovf_flag", 32'(bif.overflow), 1);
        chk("ovf_len", 32'(bif.pkt_len), 32'(DP));

        // Idle owner
        bif.req = 2'b01;
        sbq.push_back(mk_ev(EV_NEXT, 2'b00, 6'd0, 8'd0, 7'd0));
        cyc();
        base_cnt = n_abort;
`ifdef BUFFER_ARB_TIMEOUT_EN
        begin
            int k;
            sbq.push_back(mk_ev(EV_ABORT, 2'b00, 6'd0, 8'd0, 7'd0));
            for (k = 0; k < 40 && n_abort == base_cnt; k++) cyc();
            chk_cnt++;
            if (k >= int'(TMO) && k <= int'(TMO) + 2) pass_cnt++;
            else $display("FAIL tmo_abort: got %0d cycles want %0d..%0d", k, TMO, TMO + 2);
            bif.req = 2'b00;
            cyc();
        end
`else
        repeat (100) cyc();
        chk("no_tmo_abort", 32'(n_abort), 32'(base_cnt));
        chk("no_tmo_grant", 32'(bif.grant), 32'h1);
        bif.req = 2'b00;
        cyc();
        sbq.push_back(mk_ev(EV_ABORT, 2'b00, 6'd0, 8'd0, 7'd0));
        cyc();
`endif

        repeat (3) cyc();
        chk("sb_drain", 32'(sbq.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
